// File: rtl/eq_band_mixer_pkg.sv
// rtl/eq_band_mixer_pkg.sv - shared types and width/limit helpers for the band mixer
// Holds the FSM encoding, accumulator sizing and signed saturation limits.
package eq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2,
      OUT  = 2'd3
   } eq_state_t;

   // Headroom: product growth plus one bit per doubling of the band count.
   function automatic int acc_w(input int n_bands, input int data_w, input int gain_w);
      return data_w + gain_w + $clog2(n_bands) + 1;
   endfunction

   function automatic longint sat_max(input int data_w);
      return (longint'(1) <<< (data_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int data_w);
      return -(longint'(1) <<< (data_w - 1));
   endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - sample/gain/control inputs and mixed-sample outputs of the mixer
interface eq_band_mixer_if #(
   parameter int N_BANDS = 3,
   parameter int DATA_W  = 16,
   parameter int GAIN_W  = 4
);
   logic                         i_sample_stb;
   logic [N_BANDS*DATA_W-1:0]    i_band_data;
   logic [N_BANDS*GAIN_W-1:0]    i_gain;
   logic                         i_mute;
   logic                         i_flag_clr;
   logic signed [DATA_W-1:0]     o_data;
   logic                         o_valid;
   logic                         o_busy;
   logic                         o_clip;
   logic                         o_overrun;

   modport master (
      output i_sample_stb, i_band_data, i_gain, i_mute, i_flag_clr,
      input  o_data, o_valid, o_busy, o_clip, o_overrun
   );

   modport slave (
      input  i_sample_stb, i_band_data, i_gain, i_mute, i_flag_clr,
      output o_data, o_valid, o_busy, o_clip, o_overrun
   );
endinterface

// File: rtl/eq_round_sat.sv
// rtl/eq_round_sat.sv - round-half-up, fractional shift and signed saturation of the accumulator
module eq_round_sat
   import eq_pkg::*;
#(
   parameter int ACC_W     = 23,
   parameter int DATA_W    = 16,
   parameter int GAIN_FRAC = 2
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic signed [DATA_W-1:0] o_data,
   output logic                     o_clipped
);
   // Half an LSB of the output; collapses to zero when the gain has no fraction.
   localparam logic signed [ACC_W-1:0] RND   = ACC_W'((1 << GAIN_FRAC) >> 1);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_W));
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_W));

   logic signed [ACC_W-1:0] w_rnd;
   logic signed [ACC_W-1:0] w_shift;

   always_comb begin
      w_rnd     = i_acc + RND;
      w_shift   = w_rnd >>> GAIN_FRAC;
      o_data    = w_shift[DATA_W-1:0];
      o_clipped = 1'b0;
      if (w_shift > MAX_V) begin
         o_data    = MAX_V[DATA_W-1:0];
         o_clipped = 1'b1;
      end else if (w_shift < MIN_V) begin
         o_data    = MIN_V[DATA_W-1:0];
         o_clipped = 1'b1;
      end
   end
endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain, time-multiplexed MAC, round/saturate to DAC width
// One band is accumulated per cycle; mute, sticky clip and sticky overrun flags included.
module eq_band_mixer
   import eq_pkg::*;
#(
   parameter int N_BANDS   = 3,
   parameter int DATA_W    = 16,
   parameter int GAIN_W    = 4,
   parameter int GAIN_FRAC = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   eq_band_mixer_if.slave bus
);
   localparam int ACC_W  = acc_w(N_BANDS, DATA_W, GAIN_W);
   localparam int IDX_W  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
   localparam int PROD_W = DATA_W + GAIN_W + 1;

   eq_state_t                    r_state;
   eq_state_t                    w_next;
   logic [N_BANDS*DATA_W-1:0]    r_band;
   logic [N_BANDS*GAIN_W-1:0]    r_gain;
   logic                         r_mute;
   logic signed [ACC_W-1:0]      r_acc;
   logic [IDX_W-1:0]             r_idx;
   logic signed [DATA_W-1:0]     r_data;
   logic                         r_clip;
   logic                         r_overrun;

   logic                         w_busy;
   logic                         w_valid;
   logic signed [DATA_W-1:0]     w_band;
   logic signed [GAIN_W:0]       w_gain;
   logic signed [PROD_W-1:0]     w_prod;
   logic signed [ACC_W-1:0]      w_acc_next;
   logic signed [DATA_W-1:0]     w_sat_data;
   logic                         w_sat_clip;
   logic                         w_overrun_set;

   // Gain codes are unsigned, so a zero sign bit keeps the multiply signed-correct.
   always_comb begin
      w_band     = r_band[int'(r_idx)*DATA_W +: DATA_W];
      w_gain     = {1'b0, r_gain[int'(r_idx)*GAIN_W +: GAIN_W]};
      w_prod     = w_band * w_gain;
      w_acc_next = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   end

   eq_round_sat #(
      .ACC_W     (ACC_W),
      .DATA_W    (DATA_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_round_sat (
      .i_acc     (r_acc),
      .o_data    (w_sat_data),
      .o_clipped (w_sat_clip)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_busy  = 1'b1;
      w_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (bus.i_sample_stb) w_next = MAC;
         end
         MAC: begin
            if (r_idx == IDX_W'(N_BANDS - 1)) w_next = SAT;
         end
         SAT: w_next = OUT;
         OUT: begin
            w_valid = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_overrun_set = bus.i_sample_stb && (r_state != IDLE);

   // o_data is loaded on the SAT edge so it is already stable while o_valid is high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_band    <= '0;
         r_gain    <= '0;
         r_mute    <= 1'b0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_clip    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_sample_stb) begin
                  r_band <= bus.i_band_data;
                  r_gain <= bus.i_gain;
                  r_mute <= bus.i_mute;
                  r_acc  <= '0;
                  r_idx  <= '0;
               end
            end
            MAC: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + 1'b1;
            end
            SAT: begin
               r_data <= r_mute ? '0 : w_sat_data;
            end
            default: ;
         endcase

         if (r_state == SAT && w_sat_clip) begin
            r_clip <= 1'b1;
         end else if (bus.i_flag_clr) begin
            r_clip <= 1'b0;
         end

         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (bus.i_flag_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.o_data    = r_data;
   assign bus.o_valid   = w_valid;
   assign bus.o_busy    = w_busy;
   assign bus.o_clip    = r_clip;
   assign bus.o_overrun = r_overrun;
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - vector table plus scoreboard bench for eq_band_mixer
module tb_eq_band_mixer;
   localparam int N  = 3;
   localparam int DW = 16;
   localparam int GW = 4;
   localparam int GF = 2;

   typedef struct {
      string name;
      int    b0, b1, b2;
      int    g0, g1, g2;
      bit    mute;
      int    exp_data;
      bit    exp_clip;
   } vec_t;

   typedef struct {
      string name;
      int    data;
      bit    clip;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   eq_band_mixer_if #(.N_BANDS(N), .DATA_W(DW), .GAIN_W(GW)) bus_if ();

   eq_band_mixer #(
      .N_BANDS   (N),
      .DATA_W    (DW),
      .GAIN_W    (GW),
      .GAIN_FRAC (GF)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int b0, input int b1, input int b2,
                       input int g0, input int g1, input int g2, input bit mute);
      bus_if.i_band_data = {16'(b2), 16'(b1), 16'(b0)};
      bus_if.i_gain      = {4'(g2), 4'(g1), 4'(g0)};
      bus_if.i_mute      = mute;
   endtask

   task automatic scramble();
      bus_if.i_band_data = 48'({$urandom(), $urandom()});
      bus_if.i_gain      = 12'($urandom());
      bus_if.i_mute      = 1'($urandom());
   endtask

   task automatic expect_out(input string name, input int data, input bit clip);
      exp_t e;
      e.name = name;
      e.data = data;
      e.clip = clip;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus_if.o_busy && n < 20) begin
         tick();
         n++;
      end
      if (bus_if.o_busy) check({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic add_vec(input string name, input int b0, input int b1, input int b2,
                          input int g0, input int g1, input int g2, input bit mute,
                          input int exp_data, input bit exp_clip);
      vec_t v;
      v.name = name;
      v.b0 = b0; v.b1 = b1; v.b2 = b2;
      v.g0 = g0; v.g1 = g1; v.g2 = g2;
      v.mute = mute;
      v.exp_data = exp_data;
      v.exp_clip = exp_clip;
      vecs.push_back(v);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus_if.o_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_data"}, bus_if.o_data, e.data);
            check({e.name, "_clip"}, bus_if.o_clip, e.clip);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.i_sample_stb = 1'b0;
      bus_if.i_flag_clr   = 1'b0;
      load(0, 0, 0, 0, 0, 0, 1'b0);

      add_vec("unity_sum",  100, 200, 300, 4, 4, 4, 1'b0, 600, 1'b0);
      add_vec("pos_sat",    20000, 20000, 20000, 4, 4, 4, 1'b0, 32767, 1'b1);
      add_vec("neg_sat",    -20000, -20000, -20000, 4, 4, 4, 1'b0, -32768, 1'b1);
      add_vec("rnd_p1",     1, 999, -999, 2, 0, 0, 1'b0, 1, 1'b0);
      add_vec("rnd_m1",     -1, 999, -999, 2, 0, 0, 1'b0, 0, 1'b0);
      add_vec("rnd_m3",     -3, 999, -999, 2, 0, 0, 1'b0, -1, 1'b0);
      add_vec("mute",       1000, 1000, 1000, 4, 4, 4, 1'b1, 0, 1'b0);
      add_vec("unmute",     1000, 1000, 1000, 4, 4, 4, 1'b0, 3000, 1'b0);
      add_vec("mixed_gain", 5000, 100, -7, 0, 15, 3, 1'b0, 370, 1'b0);
      add_vec("half_neg",   -2, 0, 0, 1, 0, 0, 1'b0, 0, 1'b0);
      add_vec("max_pos",    32767, 0, 0, 4, 0, 0, 1'b0, 32767, 1'b0);
      add_vec("max_neg",    -32768, 0, 0, 4, 0, 0, 1'b0, -32768, 1'b0);
      add_vec("gain_max",   32767, 32767, 32767, 15, 15, 15, 1'b0, 32767, 1'b1);
      add_vec("mute_clip",  20000, 20000, 20000, 4, 4, 4, 1'b1, 0, 1'b1);

      // Reset state
      tick(); tick(); tick();
      check("rst_data", bus_if.o_data, 0);
      check("rst_valid", bus_if.o_valid, 0);
      check("rst_busy", bus_if.o_busy, 0);
      check("rst_clip", bus_if.o_clip, 0);
      check("rst_overrun", bus_if.o_overrun, 0);
      rst_n = 1'b1;
      tick();

      // Latency and busy window, strobe in cycle 0
      load(100, 200, 300, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      expect_out("latency", 600, 1'b0);
      check("lat_busy_c0", bus_if.o_busy, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c == 1) begin
            bus_if.i_sample_stb = 1'b0;
            scramble();
         end
         check($sformatf("lat_busy_c%0d", c), bus_if.o_busy, (c <= 5) ? 1 : 0);
         check($sformatf("lat_valid_c%0d", c), bus_if.o_valid, (c == 5) ? 1 : 0);
      end

      // Table of frames; flags cleared on each strobe so o_clip reflects that frame
      for (int i = 0; i < vecs.size(); i++) begin
         load(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].mute);
         bus_if.i_sample_stb = 1'b1;
         bus_if.i_flag_clr   = 1'b1;
         expect_out(vecs[i].name, vecs[i].exp_data, vecs[i].exp_clip);
         tick();
         bus_if.i_sample_stb = 1'b0;
         bus_if.i_flag_clr   = 1'b0;
         scramble();
         wait_idle(vecs[i].name);
      end

      // Sticky clip holds until cleared
      tick();
      check("clip_sticky", bus_if.o_clip, 1);
      bus_if.i_flag_clr = 1'b1;
      tick();
      bus_if.i_flag_clr = 1'b0;
      check("clip_cleared", bus_if.o_clip, 0);

      // Overrun: second strobe in cycle 3 is ignored
      load(1000, 1000, 1000, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      expect_out("ovr_first", 3000, 1'b0);
      tick();
      bus_if.i_sample_stb = 1'b0;
      check("ovr_pre", bus_if.o_overrun, 0);
      tick();
      tick();
      load(5, 5, 5, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      tick();
      bus_if.i_sample_stb = 1'b0;
      check("ovr_set", bus_if.o_overrun, 1);
      wait_idle("ovr_first");
      tick();

      // Clear and set in the same cycle: set wins; clear alone then clears
      load(1, 1, 1, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      expect_out("clr_set", 3, 1'b0);
      tick();
      bus_if.i_sample_stb = 1'b0;
      tick();
      bus_if.i_sample_stb = 1'b1;
      bus_if.i_flag_clr   = 1'b1;
      tick();
      bus_if.i_sample_stb = 1'b0;
      check("clr_set_same", bus_if.o_overrun, 1);
      tick();
      bus_if.i_flag_clr = 1'b0;
      check("clr_only", bus_if.o_overrun, 0);
      wait_idle("clr_set");

      // Strobe during the o_valid cycle counts as busy
      load(2, 2, 2, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      expect_out("ovr_valid", 6, 1'b0);
      tick();
      bus_if.i_sample_stb = 1'b0;
      tick(); tick(); tick(); tick();
      check("ovr_valid_c5", bus_if.o_valid, 1);
      load(7, 7, 7, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      tick();
      bus_if.i_sample_stb = 1'b0;
      check("ovr_valid_flag", bus_if.o_overrun, 1);
      check("ovr_valid_ignored", bus_if.o_busy, 0);
      tick();

      // Reset mid-frame discards the frame
      load(1000, 1000, 1000, 4, 4, 4, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      tick();
      bus_if.i_sample_stb = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("mid_rst_data", bus_if.o_data, 0);
      check("mid_rst_valid", bus_if.o_valid, 0);
      check("mid_rst_busy", bus_if.o_busy, 0);
      check("mid_rst_clip", bus_if.o_clip, 0);
      check("mid_rst_overrun", bus_if.o_overrun, 0);
      tick();
      rst_n = 1'b1;
      tick();

      load(-100, 50, 7, 4, 8, 3, 1'b0);
      bus_if.i_sample_stb = 1'b1;
      expect_out("post_rst", 5, 1'b0);
      tick();
      bus_if.i_sample_stb = 1'b0;
      scramble();
      wait_idle("post_rst");
      tick(); tick();

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
